kb_char_sequencer: RTL and testbench

//   Sequences raw PS/2 scan-code bytes from the keyboard interface into a stream of ASCII characters.
//   - Decodes the make/break (F0) and extended (E0) prefixes.
//   - Tracks shift and caps-lock state.
//   - Drives the scan-code->ASCII translator, applies letter case and special keys.
//   - Buffers finished characters in a FIFO with a valid/ready handshake for the text/display writer.

---
 rtl/kb_char_sequencer.sv | 113 +++++++++++
 tb/tb_kb_char_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/kb_char_sequencer.sv
// kb_char_sequencer: turns PS/2 scan-code bytes into a buffered ASCII character stream
// Ports:
//   clk, reset (async, active-low)
//   scan_code/scan_code_ready   keyboard byte and its 1-cycle strobe
//   xlat_code -> translator, xlat_ascii <- translator (combinational)
//   char_out/char_valid/char_ready  show-ahead FIFO head with valid/ready handshake
//   upper_case                  registered (shift_l | shift_r) ^ caps_lock
//   overflow                    1-cycle pulse when a char is dropped on a full FIFO
//   fifo_count                  registered FIFO occupancy 0..FIFO_DEPTH
module kb_char_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        scan_code,
    input  logic              scan_code_ready,
    output logic [7:0]        xlat_code,
    input  logic [6:0]        xlat_ascii,
    output logic [7:0]        char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              upper_case,
    output logic              overflow,
    output logic [ADDR_W:0]   fifo_count
);
    typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, LOOKUP, PUSH} state_t;
    state_t state, state_nx;
    logic shift_l, shift_r, caps_lock, shift_l_nx, shift_r_nx, caps_nx;
    logic idle_strb, brk_strb, is_mod, is_alpha;
    logic [6:0] ch, ch_nx;
    logic ch_ok, ch_ok_nx;
    logic wr_req, wr_en, pop, full;
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic [6:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;

    assign is_mod = scan_code == 8'h12 || scan_code == 8'h59 || scan_code == 8'h58;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (scan_code_ready) state_nx = scan_code == 8'hF0 ? BRK : scan_code == 8'hE0 ? EXT : is_mod ? IDLE : LOOKUP;
            BRK:     if (scan_code_ready) state_nx = IDLE;
            EXT:     if (scan_code_ready) state_nx = scan_code == 8'hF0 ? EXT_BRK : IDLE;
            EXT_BRK: if (scan_code_ready) state_nx = IDLE;
            LOOKUP:  state_nx = PUSH;
            default: state_nx = IDLE;
        endcase
    end

    assign idle_strb  = state == IDLE && scan_code_ready;
    assign brk_strb   = state == BRK && scan_code_ready;
    assign shift_l_nx = idle_strb && scan_code == 8'h12 ? 1'b1 : brk_strb && scan_code == 8'h12 ? 1'b0 : shift_l;
    assign shift_r_nx = idle_strb && scan_code == 8'h59 ? 1'b1 : brk_strb && scan_code == 8'h59 ? 1'b0 : shift_r;
    assign caps_nx    = caps_lock ^ (idle_strb && scan_code == 8'h58);

    // Special keys win over the translator; a space from any key but 29 marks an unmapped code.
    assign is_alpha = xlat_ascii >= 7'd65 && xlat_ascii <= 7'd90;
    assign ch_nx    = xlat_code == 8'h66 ? 7'd8 : xlat_code == 8'h5A ? 7'd13 :
                      (is_alpha && !upper_case) ? xlat_ascii + 7'd32 : xlat_ascii;
    assign ch_ok_nx = xlat_code == 8'h66 || xlat_code == 8'h5A || !(xlat_ascii == 7'd32 && xlat_code != 8'h29);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            xlat_code  <= '0;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            caps_lock  <= 1'b0;
            upper_case <= 1'b0;
            ch         <= '0;
            ch_ok      <= 1'b0;
        end else begin
            shift_l    <= shift_l_nx;
            shift_r    <= shift_r_nx;
            caps_lock  <= caps_nx;
            // Built from next-state values so the flag is visible the cycle after the strobe.
            upper_case <= (shift_l_nx | shift_r_nx) ^ caps_nx;
            if (idle_strb && state_nx == LOOKUP) xlat_code <= scan_code;
            if (state == LOOKUP) begin
                ch    <= ch_nx;
                ch_ok <= ch_ok_nx;
            end
        end

    always_comb begin
        wr_req   = state == PUSH && ch_ok;
        pop      = char_valid && char_ready;
        full     = fifo_count == (ADDR_W+1)'(FIFO_DEPTH);
        wr_en    = wr_req && (!full || pop);
        overflow = wr_req && full && !pop;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            rd_ptr     <= rd_ptr + ADDR_W'(pop);
            wr_ptr     <= wr_ptr + ADDR_W'(wr_en);
            fifo_count <= fifo_count + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
        end

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= ch;

    assign char_valid = fifo_count != '0;
    assign char_out   = char_valid ? {1'b0, mem[rd_ptr]} : 8'h00;
endmodule

// File: tb/tb_kb_char_sequencer.sv
// tb_kb_char_sequencer: scoreboard bench for kb_char_sequencer with a prefix/shift reference model
// Ports: none (drives clk, reset, scan stream, char_ready; models the translator)
module tb_kb_char_sequencer;
    logic clk, reset, scan_code_ready, char_ready, char_valid, upper_case, overflow;
    logic [7:0] scan_code, xlat_code, char_out;
    logic [6:0] xlat_ascii;
    logic [3:0] fifo_count;
    int n_cmp, n_err, ovf_cnt, o0;
    bit m_rel, m_ext, m_shl, m_shr, m_caps, rdone;
    logic [7:0] sbq [$];
    logic [7:0] pool [15] = '{8'h1C, 8'h32, 8'h21, 8'h45, 8'h16, 8'h29, 8'h05, 8'h12,
                              8'h59, 8'h58, 8'hF0, 8'hE0, 8'h66, 8'h5A, 8'h75};
    logic [7:0] letters [3] = '{8'h1C, 8'h32, 8'h21};

    function automatic logic [6:0] xl(input logic [7:0] c);
        case (c)
            8'h1C: return 7'h41;
            8'h32: return 7'h42;
            8'h21: return 7'h43;
            8'h45: return 7'h30;
            8'h16: return 7'h31;
            8'h29: return 7'h20;
            default: return 7'h20;
        endcase
    endfunction

    assign xlat_ascii = xl(xlat_code);

    kb_char_sequencer dut (
        .clk(clk), .reset(reset), .scan_code(scan_code), .scan_code_ready(scan_code_ready),
        .xlat_code(xlat_code), .xlat_ascii(xlat_ascii), .char_out(char_out),
        .char_valid(char_valid), .char_ready(char_ready), .upper_case(upper_case),
        .overflow(overflow), .fifo_count(fifo_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Key semantics: pending release/extended prefixes swallow the following byte(s).
    task automatic model(input logic [7:0] b, output bit has, output logic [7:0] c);
        logic [6:0] a;
        has = 0;
        c = 0;
        if (m_ext && m_rel) begin m_ext = 0; m_rel = 0; end
        else if (m_ext) begin if (b == 8'hF0) m_rel = 1; else m_ext = 0; end
        else if (m_rel) begin
            if (b == 8'h12) m_shl = 0;
            if (b == 8'h59) m_shr = 0;
            m_rel = 0;
        end
        else if (b == 8'hF0) m_rel = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'h12) m_shl = 1;
        else if (b == 8'h59) m_shr = 1;
        else if (b == 8'h58) m_caps = !m_caps;
        else begin
            a = xl(b);
            if (b == 8'h66) begin has = 1; c = 8; end
            else if (b == 8'h5A) begin has = 1; c = 13; end
            else if (a == 32 && b != 8'h29) has = 0;
            else begin
                has = 1;
                c = (a >= 65 && a <= 90 && !((m_shl | m_shr) ^ m_caps)) ? {1'b0, a} + 8'd32 : {1'b0, a};
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input bit drop, input int gap);
        bit has;
        logic [7:0] c;
        @(posedge clk);
        #1 scan_code = b;
        scan_code_ready = 1;
        model(b, has, c);
        if (has && !drop) sbq.push_back(c);
        @(posedge clk);
        #1 scan_code_ready = 0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic drain(input string name);
        int k = 0;
        char_ready = 1;
        while ((sbq.size() != 0 || fifo_count != 0) && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1 check({name, "_queue_left"}, sbq.size(), 0);
        check({name, "_count"}, fifo_count, 0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; ovf_cnt = 0; rdone = 0;
        reset = 0; scan_code = 0; scan_code_ready = 0; char_ready = 1;
        {m_rel, m_ext, m_shl, m_shr, m_caps} = '0;
        fork
            forever begin
                logic [7:0] e;
                @(negedge clk);
                if (overflow) ovf_cnt++;
                if (reset && char_valid && char_ready) begin
                    n_cmp++;
                    if (sbq.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected: got %02h expected none", char_out);
                    end else begin
                        e = sbq.pop_front();
                        if (char_out !== e) begin
                            n_err++;
                            $display("FAIL sb_char: got %02h expected %02h", char_out, e);
                        end
                    end
                end
            end
            begin
                #22;
                check("rst_xlat_code", xlat_code, 0);
                check("rst_char_out", char_out, 0);
                check("rst_char_valid", char_valid, 0);
                check("rst_upper", upper_case, 0);
                check("rst_overflow", overflow, 0);
                check("rst_count", fifo_count, 0);
                @(negedge clk) reset = 1;
                // latency: strobe cycle N, valid from N+3
                send(8'h1C, 0, 0);
                check("lat_n1_valid", char_valid, 0);
                @(posedge clk);
                #1 check("lat_n2_valid", char_valid, 0);
                @(posedge clk);
                #1 check("lat_n3_valid", char_valid, 1);
                check("lat_char", char_out, 8'h61);
                repeat (4) @(posedge clk);
                send(8'h12, 0, 0);
                check("shift_upper_next", upper_case, 1);
                repeat (4) @(posedge clk);
                send(8'h1C, 0, 5); send(8'hF0, 0, 5); send(8'h1C, 0, 5); send(8'hF0, 0, 5); send(8'h12, 0, 5);
                check("shift_released", upper_case, 0);
                send(8'h1C, 0, 5);
                send(8'h58, 0, 2);
                check("caps_on", upper_case, 1);
                send(8'h1C, 0, 5); send(8'h58, 0, 5); send(8'h1C, 0, 5); send(8'h45, 0, 5);
                foreach (pool[i]) if (pool[i] inside {8'hE0, 8'h75}) send(pool[i], 0, 5);
                send(8'hE0, 0, 5); send(8'hF0, 0, 5); send(8'h75, 0, 5);
                send(8'h05, 0, 5); send(8'h66, 0, 5); send(8'h5A, 0, 5);
                drain("directed");
                // overflow: nine makes into an unserviced FIFO
                char_ready = 0;
                o0 = ovf_cnt;
                for (int i = 0; i < 9; i++) send(letters[i % 3], i == 8, 5);
                check("full_count", fifo_count, 8);
                check("ovf_pulses", ovf_cnt - o0, 1);
                send(8'h32, 0, 0);
                @(posedge clk);
                #1 char_ready = 1;
                @(negedge clk);
                check("full_pop_no_ovf", overflow, 0);
                @(posedge clk);
                #1 char_ready = 0;
                check("full_pop_count", fifo_count, 8);
                check("full_pop_pulses", ovf_cnt - o0, 1);
                drain("overflow");
                // reset while a break prefix is pending
                send(8'hF0, 0, 5);
                @(negedge clk) reset = 0;
                {m_rel, m_ext, m_shl, m_shr, m_caps} = '0;
                sbq.delete();
                @(negedge clk) reset = 1;
                send(8'h1C, 0, 3);
                check("post_rst_valid", char_valid, 1);
                check("post_rst_char", char_out, 8'h61);
                drain("reset");
                o0 = ovf_cnt;
                fork
                    begin
                        for (int i = 0; i < 300; i++)
                            send(pool[$urandom_range(0, 14)], 0, $urandom_range(4, 8));
                        rdone = 1;
                    end
                    while (!rdone) begin
                        @(posedge clk);
                        #2 char_ready = $urandom_range(0, 3) != 0;
                    end
                join
                drain("random");
                check("random_no_ovf", ovf_cnt - o0, 0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        join_any
    end
endmodule
